idu_issue_ctrl: RTL

- Issue/stall controller between the decode output flop and the execute stage.
- Keeps a register scoreboard for long-latency writers (loads, mul/div) and an outstanding-load counter.
- Owns a multi-cycle divider busy sequencer.
- Generates pipe_stall for the decode stages and a one-cycle issue strobe for execute.

---
 rtl/idu_issue_ctrl_pkg.sv | 27 ++
 rtl/idu_scoreboard.sv | 40 ++++
 rtl/idu_issue_ctrl.sv | 136 +++++++++++++
 3 files changed

// File: rtl/idu_issue_ctrl_pkg.sv
// Shared types and defaults for the decode issue/stall controller.
package idu_issue_ctrl_pkg;

  localparam int DIV_LAT_DEF = 8;
  localparam int MAX_LD_DEF  = 2;

  typedef enum logic {
    DIV_IDLE = 1'b0,
    DIV_BUSY = 1'b1
  } div_state_e;

  // Bypassed pending bits for the three operand slots of the decode instruction.
  typedef struct packed {
    logic rs1;
    logic rs2;
    logic rd;
  } sb_eff_t;

  // One-hot register select; x0 never maps to a live bit.
  function automatic logic [31:0] reg_onehot(input logic [4:0] addr);
    logic [31:0] oh;
    oh    = 32'd1 << addr;
    oh[0] = 1'b0;
    return oh;
  endfunction

endpackage

// File: rtl/idu_scoreboard.sv
// Pending-write scoreboard for long-latency producers, with writeback bypass
// on the read side so a consumer can leave decode in its producer's writeback cycle.
module idu_scoreboard
  import idu_issue_ctrl_pkg::*;
#(
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            set_en,
  input  logic [4:0]      set_addr,
  input  logic [NREG-1:0] clr,
  input  logic [4:0]      rs1_addr,
  input  logic [4:0]      rs2_addr,
  input  logic [4:0]      rd_addr,
  output logic [NREG-1:0] sb_pending,
  output sb_eff_t         eff
);

  localparam logic [NREG-1:0] X0_MASK = {{(NREG-1){1'b1}}, 1'b0};

  logic [31:0]     set_full;
  logic [NREG-1:0] set_vec;
  logic [NREG-1:0] eff_vec;

  assign set_full = reg_onehot(set_addr);
  assign set_vec  = set_en ? set_full[NREG-1:0] : '0;
  assign eff_vec  = sb_pending & ~clr;

  assign eff.rs1 = (rs1_addr != 5'd0) & eff_vec[rs1_addr];
  assign eff.rs2 = (rs2_addr != 5'd0) & eff_vec[rs2_addr];
  assign eff.rd  = (rd_addr  != 5'd0) & eff_vec[rd_addr];

  // Clear first, then set, so a same-cycle reissue to a retiring rd stays pending.
  always_ff @(posedge clk) begin
    if (rst) sb_pending <= '0;
    else     sb_pending <= (eff_vec | set_vec) & X0_MASK;
  end

endmodule

// File: rtl/idu_issue_ctrl.sv
// Issue/stall control between decode and execute: scoreboard hazards,
// outstanding-load limit and the multi-cycle divider sequencer.
module idu_issue_ctrl
  import idu_issue_ctrl_pkg::*;
#(
  parameter int DIV_LAT = DIV_LAT_DEF,
  parameter int MAX_LD  = MAX_LD_DEF,
  parameter int NREG    = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            dec_valid,
  input  logic            dec_rs1,
  input  logic            dec_rs2,
  input  logic [4:0]      dec_rs1_addr,
  input  logic [4:0]      dec_rs2_addr,
  input  logic            dec_rd,
  input  logic [4:0]      dec_rd_addr,
  input  logic            dec_load,
  input  logic            dec_div,
  input  logic            flush,
  input  logic            ld_wb_valid,
  input  logic [4:0]      ld_wb_rd,
  output logic            issue,
  output logic            pipe_stall,
  output logic            div_busy,
  output logic            div_done,
  output logic [4:0]      div_rd,
  output logic [NREG-1:0] sb_pending
);

  localparam logic [4:0] DIV_RELOAD = 5'(DIV_LAT - 1);
  localparam logic [2:0] LD_FULL    = 3'(MAX_LD);

  div_state_e      div_state, div_state_n;
  logic [4:0]      div_cnt, div_cnt_n, div_rd_n;
  logic            div_done_n;
  logic [2:0]      ld_cnt;
  logic [31:0]     clr_full;
  logic [NREG-1:0] clr;
  sb_eff_t         eff;
  logic            hazard, go, set_en, div_issue, ld_issue, ld_ret;

  // Writeback clears; a returning load and a finishing divide may name the same rd.
  always_comb begin
    clr_full = '0;
    if (ld_wb_valid) clr_full = clr_full | reg_onehot(ld_wb_rd);
    if (div_done)    clr_full = clr_full | reg_onehot(div_rd);
  end
  assign clr = clr_full[NREG-1:0];

  assign set_en = issue & dec_rd & (dec_load | dec_div);

  idu_scoreboard #(.NREG(NREG)) u_sb (
    .clk        (clk),
    .rst        (rst),
    .set_en     (set_en),
    .set_addr   (dec_rd_addr),
    .clr        (clr),
    .rs1_addr   (dec_rs1_addr),
    .rs2_addr   (dec_rs2_addr),
    .rd_addr    (dec_rd_addr),
    .sb_pending (sb_pending),
    .eff        (eff)
  );

  // A finishing divider or a returning load frees its resource in the same cycle.
  assign hazard = (dec_rs1 & eff.rs1) | (dec_rs2 & eff.rs2) | (dec_rd & eff.rd)
                | (dec_div & div_busy & ~div_done)
                | (dec_load & (ld_cnt == LD_FULL) & ~ld_wb_valid);

  assign go         = dec_valid & ~flush;
  assign issue      = go & ~hazard;
  assign pipe_stall = go & hazard;
  assign div_issue  = issue & dec_div;
  assign ld_issue   = issue & dec_load;
  assign ld_ret     = ld_wb_valid & (ld_cnt != 3'd0);
  assign div_busy   = (div_state == DIV_BUSY);

  // Outstanding-load count; a spurious return at zero is dropped.
  always_ff @(posedge clk) begin
    if (rst)                      ld_cnt <= 3'd0;
    else if (ld_issue && !ld_ret) ld_cnt <= ld_cnt + 3'd1;
    else if (!ld_issue && ld_ret) ld_cnt <= ld_cnt - 3'd1;
  end

  a_ld_underflow: assert property (@(posedge clk) disable iff (rst)
    !(ld_wb_valid && ld_cnt == 3'd0));

  // Divider sequencer: done pulses DIV_LAT cycles after issue; back-to-back reload on done.
  always_comb begin
    div_state_n = div_state;
    div_cnt_n   = div_cnt;
    div_rd_n    = div_rd;
    div_done_n  = 1'b0;
    case (div_state)
      DIV_IDLE: begin
        if (div_issue) begin
          div_state_n = DIV_BUSY;
          div_cnt_n   = DIV_RELOAD;
          div_rd_n    = dec_rd ? dec_rd_addr : 5'd0;
        end
      end
      DIV_BUSY: begin
        if (div_done) begin
          if (div_issue) begin
            div_cnt_n = DIV_RELOAD;
            div_rd_n  = dec_rd ? dec_rd_addr : 5'd0;
          end else begin
            div_state_n = DIV_IDLE;
          end
        end else begin
          div_cnt_n  = div_cnt - 5'd1;
          div_done_n = (div_cnt == 5'd1);
        end
      end
      default: div_state_n = DIV_IDLE;
    endcase
  end

  // Divider state register; reset abandons any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_state <= DIV_IDLE;
      div_cnt   <= 5'd0;
      div_done  <= 1'b0;
      div_rd    <= 5'd0;
    end else begin
      div_state <= div_state_n;
      div_cnt   <= div_cnt_n;
      div_done  <= div_done_n;
      div_rd    <= div_rd_n;
    end
  end

endmodule
